// File: rtl/image_proto_pkg.sv
// Shared definitions for the UART image protocol endpoints.
// Holds the framing byte constants, the transmit FSM state type and a
// helper that turns a decimal digit position into its ASCII character.
package image_proto_pkg;

    localparam logic [7:0] SOH     = 8'h01;
    localparam logic [7:0] ACK     = 8'h06;
    localparam logic [7:0] ETX     = 8'h03;
    localparam logic [7:0] SYN     = 8'h16;
    localparam logic [7:0] COMMA   = 8'h2C;
    localparam logic [7:0] ETX_SUB = 8'h02;

    localparam int unsigned HDR_LEN = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_HDR  = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_SEND_ETX  = 3'd4,
        ST_WAIT_SYN  = 3'd5
    } state_t;

    // ASCII character of the least significant decimal digit of value
    function automatic logic [7:0] ascii_digit(input int unsigned value);
        return 8'(32'h30 + (value % 10));
    endfunction

endpackage

// File: rtl/image_send_if.sv
// Byte-level bus of the image transmitter.
//   pixel_*  : upstream pixel source (valid/ready)
//   tx_*     : UART transmitter port (valid/ready)
//   rx_*     : UART receiver port (single-cycle strobe)
// master = image_send side, slave = the surrounding source/UART side.
interface image_send_if;

    logic [7:0] pixel_data;
    logic       pixel_valid;
    logic       pixel_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        input  pixel_data, pixel_valid,
        output pixel_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid
    );

    modport slave (
        output pixel_data, pixel_valid,
        input  pixel_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid
    );

endinterface

// File: rtl/image_send_resp_timer.sv
// resp_timer: loadable down-counter used to time out handshake responses.
//   clear      : force count to zero
//   load       : load load_value (takes priority over enable)
//   enable     : count down while non-zero
//   expired_c  : enable && count == 0
module resp_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] load_value,
    output logic             expired_c
);

    logic [CNT_W-1:0] count;

    // count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired_c = enable && (count == '0);

endmodule

// File: rtl/image_send.sv
// image_send: transmit endpoint of the UART image protocol.
// Sends SOH header, waits for ACK (with retries), streams the pixels with
// 0x03 remapped to 0x02, sends ETX, then waits for SYN.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : begin a transfer (sampled in IDLE only)
//   bus          : pixel source, UART tx and rx byte ports
//   busy         : not in IDLE
//   done / error : one-cycle completion / failure pulses
module image_send
    import image_proto_pkg::*;
#(
    parameter int unsigned WIDTH_PX    = 64,
    parameter int unsigned HEIGHT_PX   = 64,
    parameter int unsigned ACK_TIMEOUT = 27_000_000,
    parameter int unsigned MAX_RETRIES = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    image_send_if.master bus,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int unsigned TMR_W   = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [19:0] PIX_LAST = 20'(WIDTH_PX * HEIGHT_PX - 1);
    localparam logic [2:0]  HDR_LAST = 3'(HDR_LEN - 1);
    // Timer expires on the ACK_TIMEOUT-th cycle spent in a wait state
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

    state_t             state, state_n;
    logic [2:0]         hdr_idx, hdr_idx_n;
    logic [RETRY_W-1:0] retry_cnt, retry_n;
    logic [19:0]        pix_cnt, pix_n;
    logic               busy_n, done_n, error_n;
    logic               tmr_clear, tmr_load, tmr_en, tmr_expired_c;
    logic [7:0]         hdr_byte_c, pix_sub_c;

    resp_timer #(.CNT_W(TMR_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (tmr_clear),
        .load       (tmr_load),
        .enable     (tmr_en),
        .load_value (TMR_LOAD),
        .expired_c  (tmr_expired_c)
    );

    // header byte selection
    always_comb begin
        case (hdr_idx)
            3'd0:    hdr_byte_c = SOH;
            3'd1:    hdr_byte_c = ascii_digit(WIDTH_PX / 100);
            3'd2:    hdr_byte_c = ascii_digit(WIDTH_PX / 10);
            3'd3:    hdr_byte_c = ascii_digit(WIDTH_PX);
            3'd4:    hdr_byte_c = COMMA;
            3'd5:    hdr_byte_c = HEIGHT_PX[7:0];
            default: hdr_byte_c = 8'h00;
        endcase
    end

    // the peer reads 0x03 as end of image
    assign pix_sub_c = (bus.pixel_data == ETX) ? ETX_SUB : bus.pixel_data;

    // state and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            hdr_idx   <= '0;
            retry_cnt <= '0;
            pix_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            hdr_idx   <= hdr_idx_n;
            retry_cnt <= retry_n;
            pix_cnt   <= pix_n;
            busy      <= busy_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

    // next state and byte-port outputs
    always_comb begin
        state_n         = state;
        hdr_idx_n       = hdr_idx;
        retry_n         = retry_cnt;
        pix_n           = pix_cnt;
        done_n          = 1'b0;
        error_n         = 1'b0;
        tmr_clear       = 1'b0;
        tmr_load        = 1'b0;
        tmr_en          = 1'b0;
        bus.tx_valid    = 1'b0;
        bus.tx_data     = 8'h00;
        bus.pixel_ready = 1'b0;

        case (state)
            ST_IDLE: begin
                tmr_clear = 1'b1;
                if (start) begin
                    retry_n   = '0;
                    hdr_idx_n = '0;
                    pix_n     = '0;
                    state_n   = ST_SEND_HDR;
                end
            end
            ST_SEND_HDR: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = hdr_byte_c;
                if (bus.tx_ready) begin
                    if (hdr_idx == HDR_LAST) begin
                        hdr_idx_n = '0;
                        tmr_load  = 1'b1;
                        state_n   = ST_WAIT_ACK;
                    end else begin
                        hdr_idx_n = hdr_idx + 3'd1;
                    end
                end
            end
            ST_WAIT_ACK: begin
                tmr_en = 1'b1;
                // an ACK in the expiry cycle still wins
                if (bus.rx_valid && (bus.rx_data == ACK)) begin
                    pix_n   = '0;
                    state_n = ST_SEND_DATA;
                end else if (tmr_expired_c) begin
                    if (32'(retry_cnt) < MAX_RETRIES) begin
                        retry_n   = retry_cnt + RETRY_W'(1);
                        hdr_idx_n = '0;
                        state_n   = ST_SEND_HDR;
                    end else begin
                        error_n = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_SEND_DATA: begin
                bus.tx_valid    = bus.pixel_valid;
                bus.tx_data     = pix_sub_c;
                bus.pixel_ready = bus.tx_ready;
                if (bus.pixel_valid && bus.tx_ready) begin
                    if (pix_cnt == PIX_LAST) begin
                        state_n = ST_SEND_ETX;
                    end else begin
                        pix_n = pix_cnt + 20'd1;
                    end
                end
            end
            ST_SEND_ETX: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = ETX;
                if (bus.tx_ready) begin
                    tmr_load = 1'b1;
                    state_n  = ST_WAIT_SYN;
                end
            end
            ST_WAIT_SYN: begin
                tmr_en = 1'b1;
                if (bus.rx_valid && (bus.rx_data == SYN)) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end else if (tmr_expired_c) begin
                    error_n = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_image_send.sv
// Self-checking bench for image_send (W=4, H=2, timeout 100, 3 retries).
// A single directed sequence drives stimulus cycle by cycle; accepted tx
// bytes are collected and compared against a frame model built from the
// protocol rules.
module tb_image_send;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 2;
    localparam int unsigned T    = 100;
    localparam int unsigned MR   = 3;
    localparam int unsigned NPIX = W * H;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic busy, done, error;

    image_send_if bus();

    image_send #(
        .WIDTH_PX    (W),
        .HEIGHT_PX   (H),
        .ACK_TIMEOUT (T),
        .MAX_RETRIES (MR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   px_taken = 0, done_cnt = 0, err_cnt = 0, done_t = 0, err_t = 0;
    bq_t  got;
    int   got_t[$];
    bq_t  src;
    int   pidx = 0;
    bit   tog_ready = 0, rand_valid = 0, bp_mode = 0, prev_stall_ctl = 0;
    int   bp_base = 0;
    bq_t  exp_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected byte stream: reps headers, then (optionally) pixels + ETX
    function automatic bq_t model(input bq_t px, input int reps, input bit tail);
        bq_t   q;
        string s;
        s = $sformatf("%03d", W);
        for (int r = 0; r < reps; r++) begin
            q.push_back(8'h01);
            for (int i = 0; i < 3; i++) q.push_back(8'(s[i]));
            q.push_back(8'h2C);
            q.push_back(8'(H % 256));
        end
        if (tail) begin
            foreach (px[i]) q.push_back((px[i] == 8'h03) ? 8'h02 : px[i]);
            q.push_back(8'h03);
        end
        return q;
    endfunction

    task automatic drive_pixel();
        if (pidx < src.size()) begin
            bus.pixel_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.pixel_data  = src[pidx];
        end else begin
            bus.pixel_valid = 1'b0;
            bus.pixel_data  = 8'h00;
        end
    endtask

    task automatic load_src(input bq_t q);
        src  = q;
        pidx = 0;
        drive_pixel();
    endtask

    // One clock: observe at negedge, drive new inputs 1 unit after posedge
    task automatic tick();
        bit px_acc;
        int idx;
        bit ctl;
        @(negedge clk);
        if (bp_mode) begin
            idx = got.size() - bp_base;
            ctl = (idx < 6) || (idx == 6 + int'(NPIX));
            if (prev_stall_ctl) chk("hold_valid", 32'(bus.tx_valid), 32'd1);
            if (bus.tx_valid && ctl && idx < exp_q.size())
                chk("hold_data", 32'(bus.tx_data), 32'(exp_q[idx]));
            prev_stall_ctl = bus.tx_valid && !bus.tx_ready && ctl;
        end
        if (bus.tx_valid && bus.tx_ready) begin
            got.push_back(bus.tx_data);
            got_t.push_back(cyc);
        end
        px_acc = bus.pixel_valid && bus.pixel_ready;
        if (px_acc) px_taken++;
        if (done) begin done_cnt++; done_t = cyc; end
        if (error) begin err_cnt++; err_t = cyc; end
        @(posedge clk);
        #1;
        cyc++;
        if (px_acc) pidx++;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = tog_ready ? ~bus.tx_ready : 1'b1;
        drive_pixel();
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic check_seq(input string tag, input int base, input bq_t e);
        chk({tag, "_len"}, 32'(got.size() - base), 32'(e.size()));
        for (int i = 0; i < e.size() && base + i < got.size(); i++)
            chk(tag, 32'(got[base + i]), 32'(e[i]));
    endtask

    task automatic run_xfer(input int base, input int reps);
        start = 1'b1;
        tick();
        wait_bytes(base + 6 * reps, reps * (12 + int'(T) + 4) + 10, "xfer_hdr");
        send_rx(8'h06);
        wait_bytes(base + 6 * reps + int'(NPIX) + 1, 8 * int'(NPIX) + 20, "xfer_data");
        send_rx(8'h16);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base, d0, e0, p0, k;
        bq_t q;

        reset_n         = 1'b1;
        start           = 1'b0;
        bus.tx_ready    = 1'b1;
        bus.rx_valid    = 1'b0;
        bus.rx_data     = 8'h00;
        bus.pixel_valid = 1'b0;
        bus.pixel_data  = 8'h00;
        #2 reset_n = 1'b0;
        repeat (3) tick();

        // reset values
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_pixel_ready", 32'(bus.pixel_ready), 32'd0);
        chk("rst_busy_done_err", 32'({busy, done, error}), 32'd0);
        reset_n = 1'b1;
        tick();

        // nominal transfer, pixels 0x10..0x17
        q.delete();
        for (int i = 0; i < int'(NPIX); i++) q.push_back(8'(8'h10 + i));
        load_src(q);
        base = got.size(); d0 = done_cnt; e0 = err_cnt; p0 = px_taken;
        start = 1'b1;
        tick();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_valid", 32'(bus.tx_valid), 32'd1);
        chk("start_soh", 32'(bus.tx_data), 32'h01);
        wait_bytes(base + 6, 40, "nom_hdr");
        chk("wait_pixel_ready", 32'(bus.pixel_ready), 32'd0);
        send_rx(8'h16);                      // wrong byte in WAIT_ACK
        repeat (3) tick();
        send_rx(8'h06);
        chk("ack_first_valid", 32'(bus.tx_valid), 32'd1);
        chk("ack_first_pixel", 32'(bus.tx_data), 32'h10);
        chk("nom_no_early_pix", 32'(px_taken - p0), 32'd0);
        wait_bytes(base + 15, 60, "nom_data");
        send_rx(8'h16);
        chk("nom_done", 32'(done), 32'd1);
        tick();
        chk("nom_done_pulse", 32'(done), 32'd0);
        chk("nom_busy_low", 32'(busy), 32'd0);
        chk("nom_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("nom_no_err", 32'(err_cnt - e0), 32'd0);
        check_seq("nom_seq", base, model(q, 1, 1));

        // escape + ACK landing exactly in the timeout cycle
        q.delete();
        for (int i = 0; i < int'(NPIX); i++) q.push_back(8'($urandom_range(0, 255)));
        q[1] = 8'h03;
        q[4] = 8'h02;
        load_src(q);
        base = got.size(); d0 = done_cnt; e0 = err_cnt;
        start = 1'b1;
        tick();
        wait_bytes(base + 6, 40, "esc_hdr");
        repeat (T - 1) tick();
        send_rx(8'h06);
        chk("ack_at_timeout_valid", 32'(bus.tx_valid), 32'd1);
        chk("ack_at_timeout_data", 32'(bus.tx_data), 32'((q[0] == 8'h03) ? 8'h02 : q[0]));
        wait_bytes(base + 15, 60, "esc_data");
        send_rx(8'h16);
        tick();
        check_seq("esc_seq", base, model(q, 1, 1));
        chk("esc_done", 32'(done_cnt - d0), 32'd1);
        chk("esc_no_err", 32'(err_cnt - e0), 32'd0);

        // retry: ACK only after the third header
        q.delete();
        for (int i = 0; i < int'(NPIX); i++) q.push_back(8'($urandom_range(0, 255)));
        load_src(q);
        base = got.size(); d0 = done_cnt; e0 = err_cnt;
        run_xfer(base, 3);
        check_seq("retry_seq", base, model(q, 3, 1));
        for (int r = 0; r < 2; r++)
            chk("retry_gap", 32'(got_t[base + 6 * (r + 1)] - got_t[base + 6 * r + 5]), 32'(T + 1));
        chk("retry_done", 32'(done_cnt - d0), 32'd1);
        chk("retry_no_err", 32'(err_cnt - e0), 32'd0);

        // retry exhaustion: never ACK
        load_src(q);
        base = got.size(); e0 = err_cnt; p0 = px_taken;
        start = 1'b1;
        tick();
        wait_bytes(base + 24, 4 * (12 + int'(T) + 4) + 10, "exh_hdr");
        k = 0;
        while (err_cnt == e0 && k < int'(T) + 20) begin
            tick();
            k++;
        end
        chk("exh_err_seen", 32'(err_cnt - e0), 32'd1);
        if (got_t.size() >= base + 24)
            chk("exh_err_time", 32'(err_t - got_t[base + 23]), 32'(T + 1));
        chk("exh_err_pulse", 32'(error), 32'd0);
        chk("exh_busy_low", 32'(busy), 32'd0);
        repeat (10) tick();
        check_seq("exh_seq", base, model(q, 4, 0));
        chk("exh_no_pixel", 32'(px_taken - p0), 32'd0);

        // back-pressure: tx_ready toggling, random pixel_valid
        q.delete();
        for (int i = 0; i < int'(NPIX); i++) q.push_back(8'($urandom_range(0, 255)));
        q[3] = 8'h03;
        load_src(q);
        base = got.size(); d0 = done_cnt;
        bp_base = base;
        exp_q = model(q, 1, 1);
        prev_stall_ctl = 1'b0;
        bp_mode = 1'b1; tog_ready = 1'b1; rand_valid = 1'b1;
        run_xfer(base, 1);
        bp_mode = 1'b0; tog_ready = 1'b0; rand_valid = 1'b0;
        tick();
        check_seq("bp_seq", base, exp_q);
        chk("bp_done", 32'(done_cnt - d0), 32'd1);

        // reset in the middle of the data phase
        q.delete();
        for (int i = 0; i < int'(NPIX); i++) q.push_back(8'($urandom_range(0, 255)));
        load_src(q);
        base = got.size(); p0 = px_taken;
        start = 1'b1;
        tick();
        wait_bytes(base + 6, 40, "rst_hdr");
        send_rx(8'h06);
        k = 0;
        while (px_taken - p0 < 3 && k < 40) begin
            tick();
            k++;
        end
        chk("rst_three_pixels", 32'(px_taken - p0), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_outputs",
            32'({bus.tx_valid, bus.tx_data, bus.pixel_ready, busy, done, error}), 32'd0);
        base = got.size();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("rst_no_etx", 32'(got.size() - base), 32'd0);
        load_src(q);
        start = 1'b1;
        tick();
        wait_bytes(base + 6, 40, "rst_new_hdr");
        check_seq("rst_hdr_seq", base, model(q, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
